// File: rtl/flash_read_bridge.sv
// Single-outstanding read bridge that turns byte/half/word/dword requests into 8-byte flash reads.
// Optional one-line read buffer enabled by defining FLASH_READ_BRIDGE_LINEBUF_EN.
module flash_read_bridge #(
    parameter int unsigned FLASH_BYTES = 32'd4194304
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        flash_r_en,
    output logic [31:0] flash_r_addr,
    input  logic [63:0] flash_r_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic        flash_r_en_q, flash_r_en_d;
    logic [31:0] flash_r_addr_q, flash_r_addr_d;
    logic [2:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;

    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] end_addr;
    logic        line_hit;

    // Shift the requested bytes down to bit 0 and zero everything above the access width.
    function automatic logic [63:0] extract(input logic [63:0] w, input logic [2:0] off,
                                            input logic [1:0] sz);
        logic [63:0] s;
        logic [63:0] r;
        s = w >> {off, 3'b000};
        r = 64'd0;
        case (sz)
            2'd0:    r = {56'd0, s[7:0]};
            2'd1:    r = {48'd0, s[15:0]};
            2'd2:    r = {32'd0, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign end_addr     = {1'b0, req_addr} + (33'd1 << req_size);
    assign out_of_range = end_addr > 33'(FLASH_BYTES);
    assign req_err      = misaligned | out_of_range;

`ifdef FLASH_READ_BRIDGE_LINEBUF_EN
    logic        line_valid_q, line_valid_d;
    logic [28:0] line_tag_q, line_tag_d;
    logic [63:0] line_data_q, line_data_d;

    assign line_hit = line_valid_q && (line_tag_q == req_addr[31:3]);

    always_comb begin
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        // flash_r_addr_q still carries the tag of the word being captured.
        if (state_q == StWait) begin
            line_valid_d = 1'b1;
            line_tag_d   = flash_r_addr_q[31:3];
            line_data_d  = flash_r_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_valid_q <= 1'b0;
            line_tag_q   <= 29'd0;
            line_data_q  <= 64'd0;
        end else begin
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
        end
    end
`else
    assign line_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        resp_valid_d   = resp_valid_q;
        resp_err_d     = resp_err_q;
        resp_data_d    = resp_data_q;
        flash_r_en_d   = 1'b0;
        flash_r_addr_d = flash_r_addr_q;
        off_d          = off_q;
        size_d         = size_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 64'd0;
                    end else if (line_hit) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
`ifdef FLASH_READ_BRIDGE_LINEBUF_EN
                        resp_data_d  = extract(line_data_q, req_addr[2:0], req_size);
`endif
                    end else begin
                        state_d        = StIssue;
                        flash_r_en_d   = 1'b1;
                        flash_r_addr_d = {req_addr[31:3], 3'b000};
                        off_d          = req_addr[2:0];
                        size_d         = req_size;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = extract(flash_r_data, off_q, size_q);
            end
            default: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_data_d  = 64'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_data_q    <= 64'd0;
            flash_r_en_q   <= 1'b0;
            flash_r_addr_q <= 32'd0;
            off_q          <= 3'd0;
            size_q         <= 2'd0;
        end else begin
            state_q        <= state_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_data_q    <= resp_data_d;
            flash_r_en_q   <= flash_r_en_d;
            flash_r_addr_q <= flash_r_addr_d;
            off_q          <= off_d;
            size_q         <= size_d;
        end
    end

    // Ready is gated by reset so it reads 0 for the whole time reset is held.
    assign req_ready    = (state_q == StIdle) && reset_n;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_data    = resp_data_q;
    assign flash_r_en   = flash_r_en_q;
    assign flash_r_addr = flash_r_addr_q;

endmodule

// File: tb/tb_flash_read_bridge.sv
// Self-checking bench for flash_read_bridge: directed table, stall/reset sequences, random traffic.
// Define FLASH_READ_BRIDGE_LINEBUF_EN for both DUT and bench to exercise the line buffer.
module tb_flash_read_bridge;

    localparam int unsigned FB = 32'd4194304;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        flash_r_en;
    logic [31:0] flash_r_addr;
    logic [63:0] flash_r_data;

    int vectors = 0;
    int miscompares = 0;

    int          en_cnt = 0;
    logic [31:0] en_addr = 32'd0;

    // Reference model state: last fetched flash address and the buffered line.
    logic [31:0] m_last_faddr = 32'd0;
    logic        m_lb_valid = 1'b0;
    logic [28:0] m_lb_tag = 29'd0;

    flash_read_bridge #(.FLASH_BYTES(FB)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .flash_r_en   (flash_r_en),
        .flash_r_addr (flash_r_addr),
        .flash_r_data (flash_r_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] flash_word(input logic [31:0] a);
        logic [31:0] hi;
        logic [31:0] lo;
        if (a == 32'd0) return 64'h01f292930010029b;
        hi = (a * 32'h9E3779B1) ^ 32'h12345678;
        lo = ~a ^ {a[15:0], a[31:16]};
        return {hi, lo};
    endfunction

    always @(posedge clock) begin
        if (flash_r_en) begin
            flash_r_data <= flash_word(flash_r_addr);
            en_cnt = en_cnt + 1;
            en_addr = flash_r_addr;
        end
    end

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned nbytes;
        longint unsigned last;
        nbytes = longint'(1) << sz;
        last = longint'(a) + nbytes;
        return ((longint'(a) % nbytes) != 0) || (last > longint'(FB));
    endfunction

    function automatic logic [63:0] model_data(input logic [31:0] a, input logic [1:0] sz);
        logic [63:0] w;
        int nbytes;
        nbytes = 1 << sz;
        w = flash_word(a & ~32'h7) >> (8 * int'(a % 8));
        if (nbytes < 8) w = w & ((64'd1 << (8 * nbytes)) - 64'd1);
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [1:0] sz, input int stall,
                          output logic act_err, output logic [63:0] act_data);
        logic        e_err;
        logic        e_hit;
        logic [63:0] e_data;
        int          e_lat;
        int          e_en;
        int          lat;
        logic [63:0] held_data;
        logic        held_err;

        e_err  = model_err(addr, sz);
        e_hit  = 1'b0;
`ifdef FLASH_READ_BRIDGE_LINEBUF_EN
        e_hit  = !e_err && m_lb_valid && (m_lb_tag == addr[31:3]);
`endif
        e_data = e_err ? 64'd0 : model_data(addr, sz);
        e_lat  = (e_err || e_hit) ? 1 : 3;
        e_en   = (e_err || e_hit) ? 0 : 1;

        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        en_cnt    = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = sz;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = 2'($urandom);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            @(negedge clock);
            lat = lat + 1;
        end
        chk("resp_latency", 64'(lat), 64'(e_lat));
        chk("resp_err", {63'd0, resp_err}, {63'd0, e_err});
        chk("resp_data", resp_data, e_data);
        act_err   = resp_err;
        act_data  = resp_data;
        held_data = resp_data;
        held_err  = resp_err;

        for (int s = 0; s < stall; s++) begin
            @(posedge clock);
            @(negedge clock);
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_data", resp_data, held_data);
            chk("stall_err", {63'd0, resp_err}, {63'd0, held_err});
            chk("stall_ready", {63'd0, req_ready}, 64'd0);
        end

        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        chk("resp_drop", {63'd0, resp_valid}, 64'd0);
        chk("ready_back", {63'd0, req_ready}, 64'd1);
        chk("flash_en_count", 64'(en_cnt), 64'(e_en));
        if (e_en != 0) m_last_faddr = addr & ~32'h7;
        chk("flash_addr_hold", {32'd0, flash_r_addr}, {32'd0, m_last_faddr});
        if (e_en != 0) chk("flash_addr_issued", {32'd0, en_addr}, {32'd0, m_last_faddr});
        if (!e_err) begin
            m_lb_valid = 1'b1;
            m_lb_tag   = addr[31:3];
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        exp_err;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a_err;
        logic [63:0] a_data;
        logic [31:0] ra;
        int          pick;

        tbl[0] = '{32'h0000_0004, 2'd2, 1'b0, 64'h0000_0000_01f2_9293};
        tbl[1] = '{32'h0000_0003, 2'd1, 1'b1, 64'd0};
        tbl[2] = '{32'h003F_FFF8, 2'd3, 1'b0, flash_word(32'h003F_FFF8)};
        tbl[3] = '{32'h0040_0000, 2'd0, 1'b1, 64'd0};
        tbl[4] = '{32'h003F_FFFF, 2'd0, 1'b0, {56'd0, flash_word(32'h003F_FFF8) >> 56}};
        tbl[5] = '{32'h0000_0006, 2'd1, 1'b0, 64'h0000_0000_0000_01f2};
        tbl[6] = '{32'h003F_FFFC, 2'd3, 1'b1, 64'd0};
        tbl[7] = '{32'h0000_0000, 2'd3, 1'b0, 64'h01f2_9293_0010_029b};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_size   = 2'd0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_flash_en", {63'd0, flash_r_en}, 64'd0);
        chk("rst_flash_addr", {32'd0, flash_r_addr}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].addr, tbl[i].size, 0, a_err, a_data);
            chk("tbl_err", {63'd0, a_err}, {63'd0, tbl[i].exp_err});
            chk("tbl_data", a_data, tbl[i].exp_data);
        end

        // Consumer back-pressure for five cycles.
        do_req(32'h0000_0100, 2'd3, 5, a_err, a_data);

        // Reset pulsed while the flash read is in WAIT.
        chk("pre_rst_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0020;
        req_size  = 2'd3;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_resp_data", resp_data, 64'd0);
        chk("midrst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("midrst_flash_en", {63'd0, flash_r_en}, 64'd0);
        chk("midrst_flash_addr", {32'd0, flash_r_addr}, 64'd0);
        m_lb_valid   = 1'b0;
        m_last_faddr = 32'd0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("postrst_no_resp", {63'd0, resp_valid}, 64'd0);
            chk("postrst_ready", {63'd0, req_ready}, 64'd1);
        end
        do_req(32'h0000_0020, 2'd3, 0, a_err, a_data);

        // Same-line follow-up: served from the buffer when it exists.
        do_req(32'h0000_0008, 2'd3, 0, a_err, a_data);
        do_req(32'h0000_000C, 2'd2, 0, a_err, a_data);

        for (int n = 0; n < 80; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 5)       ra = $urandom_range(0, 63);
            else if (pick < 7)  ra = FB - 32'd16 + $urandom_range(0, 23);
            else if (pick == 7) ra = $urandom;
            else                ra = $urandom_range(0, FB - 1);
            do_req(ra, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), a_err, a_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flash_read_bridge.md
FLASH_READ_BRIDGE -- requirements
Module: flash_read_bridge

Interface
REQ-001 SHALL have parameter: FLASH_BYTES, 4194304, flash capacity in bytes (multiple of 8).
REQ-002 SHALL have port: clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  read request valid.
REQ-005 SHALL have port: req_ready  output  1  bridge accepts request.
REQ-006 SHALL have port: req_addr  input  32  byte offset into flash.
REQ-007 SHALL have port: req_size  input  2  access size, 0=1B, 1=2B, 2=4B, 3=8B.
REQ-008 SHALL have port: resp_valid  output  1  response valid.
REQ-009 SHALL have port: resp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port: resp_data  output  64  read data, right-justified, zero-extended.
REQ-011 SHALL have port: resp_err  output  1  request rejected (misaligned or out of range).
REQ-012 SHALL have port: flash_r_en  output  1  read strobe to flash model.
REQ-013 SHALL have port: flash_r_addr  output  32  8-byte-aligned flash byte address.
REQ-014 SHALL have port: flash_r_data  input  64  flash data, valid the cycle after flash_r_en is sampled high.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; request accepted on edge with req_valid&&req_ready.
REQ-017 On accept, SHALL flag error if req_addr not a multiple of (1<<req_size) or req_addr+(1<<req_size) > FLASH_BYTES; error requests go IDLE->RESP with resp_err=1, resp_data=0, no flash_r_en.
REQ-018 Valid requests SHALL go IDLE->ISSUE; in ISSUE flash_r_en=1 (registered output) for exactly one cycle, flash_r_addr={req_addr[31:3],3'b000}.
REQ-019 ISSUE->WAIT unconditionally; at end of WAIT SHALL capture flash_r_data, then enter RESP.
REQ-020 resp_data SHALL equal (captured word >> 8*req_addr[2:0]) masked to 8<<req_size bits, upper bits zero; byte 0 = bits [7:0] (little-endian).
REQ-021 Miss latency: accept at edge k -> resp_valid high from edge k+3; error latency: resp_valid from edge k+1.
REQ-022 In RESP, resp_valid/resp_data/resp_err SHALL hold stable until resp_valid&&resp_ready; then return to IDLE (next request acceptable the following cycle, no same-cycle turnaround).
REQ-023 flash_r_en SHALL be 0 in all states other than ISSUE; flash_r_addr holds last value when idle.
REQ-024 At most one request outstanding; no reordering.
REQ-025 Boundary: addr=FLASH_BYTES-8, size=3 is legal; addr=FLASH_BYTES, any size, is an error; addr=FLASH_BYTES-1, size=0 legal.

Reset
REQ-026 On reset_n low, SHALL asynchronously force state IDLE, req_ready=0 while asserted, resp_valid=0, resp_data=0, resp_err=0, flash_r_en=0, flash_r_addr=0.
REQ-027 Reset mid-operation SHALL abort the transaction with no response; any flash_r_data arriving after reset is ignored.
REQ-028 After reset_n deasserts, req_ready=1 on the first clock edge in IDLE.

Configuration
REQ-029 Macro FLASH_READ_BRIDGE_LINEBUF_EN defined: SHALL keep one 64-bit line buffer with valid bit and tag req_addr[31:3], filled on every WAIT capture; a legal request whose tag matches a valid line goes IDLE->RESP (resp_valid from edge k+1) with no flash_r_en.
REQ-030 Macro defined: line valid bit cleared by reset only (flash is read-only); error requests never touch the buffer.
REQ-031 Macro undefined: no buffer logic; every legal request goes through ISSUE/WAIT.

Verification
REQ-032 Flash word at 0x0 = 0x01f292930010029b; req addr 0x4 size 2 -> flash_r_en one cycle, flash_r_addr 0x0, resp_data 0x01f29293, resp_err 0, resp_valid at k+3.
REQ-033 req addr 0x3 size 1 -> resp_err=1, resp_data=0, resp_valid at k+1, flash_r_en never asserted.
REQ-034 req addr 0x3FFFF8 size 3 -> legal, flash_r_addr 0x3FFFF8; req addr 0x400000 size 0 -> resp_err=1.
REQ-035 resp_ready held 0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0, no second flash_r_en.
REQ-036 reset_n pulsed low during WAIT -> all outputs 0 immediately, no resp_valid; next request returns correct data.
REQ-037 LINEBUF_EN defined: read 0x8 size 3 then 0xC size 2 -> second returns at k+1 with no flash_r_en; undefined: second issues flash_r_en, returns at k+3.
